// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier core among N_REQ requesters, one operation in flight.
// Latency: accept T, core start T+1, response T+2+core delay (or after TIMEOUT wait cycles with err).
// Backpressure: requests are accepted only in IDLE; requesters hold valid until their ready pulse.
module booth_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]   i_req_multiplier,
  input  logic [N_REQ*DATA_W-1:0]   i_req_multiplicand,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [2*DATA_W:0]         o_rsp_data,
  output logic                      o_rsp_err,
  output logic                      o_mul_start,
  output logic [DATA_W-1:0]         o_mul_multiplier,
  output logic [DATA_W-1:0]         o_mul_multiplicand,
  input  logic                      i_mul_done,
  input  logic [2*DATA_W:0]         i_mul_result,
  output logic                      o_busy
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d, last_grant_q, last_grant_d;
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W:0]   result_q, result_d;
  logic                err_q, err_d;
  logic                found;
  logic [GW-1:0]       grant_sel, rr_idx;
  logic [N_REQ-1:0]    req_ready;

  // Search starts one past the last served requester so nobody is granted twice in a row while others wait.
  always_comb begin
    found     = 1'b0;
    grant_sel = '0;
    rr_idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_idx = GW'((int'(last_grant_q) + i) % N_REQ);
      if (!found && i_req_valid[rr_idx]) begin
        found     = 1'b1;
        grant_sel = rr_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    err_d        = err_q;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          req_ready[grant_sel] = 1'b1;
          grant_d = grant_sel;
          opa_d   = i_req_multiplier[int'(grant_sel)*DATA_W +: DATA_W];
          opb_d   = i_req_multiplicand[int'(grant_sel)*DATA_W +: DATA_W];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done strobe on the final wait cycle still counts as success.
        if (i_mul_done) begin
          result_d = i_mul_result;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q + 1'b1 == CW'(TIMEOUT)) begin
          cnt_d    = cnt_q + 1'b1;
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      opa_q        <= '0;
      opb_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  // Ready is combinational from valid, so it is gated directly by reset to stay quiet while held.
  assign o_req_ready        = i_rst ? req_ready : '0;
  assign o_mul_start        = (state_q == ST_ISSUE);
  assign o_mul_multiplier   = opa_q;
  assign o_mul_multiplicand = opb_q;
  assign o_rsp_valid        = (state_q == ST_RESP) ? (N_REQ'(1) << grant_q) : '0;
  assign o_rsp_data         = result_q;
  assign o_rsp_err          = err_q & (state_q == ST_RESP);
  assign o_busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed + randomized bench for booth_mul_arbiter with a delay-programmable core model.
module tb_booth_mul_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 4;
  localparam int RW  = 2*DW + 1;
  localparam int TO  = 15;
  localparam int OPW = NR*DW;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [NR-1:0]   i_req_valid;
  logic [OPW-1:0]  i_req_multiplier, i_req_multiplicand;
  logic [NR-1:0]   o_req_ready, o_rsp_valid;
  logic [RW-1:0]   o_rsp_data;
  logic            o_rsp_err, o_mul_start, o_busy;
  logic [DW-1:0]   o_mul_multiplier, o_mul_multiplicand;
  logic            i_mul_done;
  logic [RW-1:0]   i_mul_result = '0;

  int              n_tests = 0, n_fail = 0, cyc = 0;
  int              core_delay = 0, core_cnt = 0;
  logic            core_done = 1'b0, spur_done = 1'b0;
  logic [RW-1:0]   core_result = '0;
  int              model_last = NR - 1;
  int              last_accept = 0, last_rsp = 0;
  logic [NR-1:0]   last_ready_oh = '0;

  assign i_mul_done = core_done | spur_done;

  booth_mul_arbiter #(.N_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_multiplier(i_req_multiplier),
    .i_req_multiplicand(i_req_multiplicand), .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_mul_start(o_mul_start), .o_mul_multiplier(o_mul_multiplier),
    .o_mul_multiplicand(o_mul_multiplicand), .i_mul_done(i_mul_done),
    .i_mul_result(i_mul_result), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Core model: done fires core_delay cycles after the start pulse (0 = never); result is noise otherwise.
  always @(negedge i_clk) begin
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) core_done = 1'b1;
    end
    if (o_mul_start) core_cnt = core_delay;
    i_mul_result = core_done ? core_result : RW'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first valid index after the last winner, wrapping.
  function automatic int rr_pick(input int last, input logic [NR-1:0] m);
    for (int i = 1; i <= NR; i++)
      if (m[(last + i) % NR]) return (last + i) % NR;
    return -1;
  endfunction

  task automatic run_txn(input logic [NR-1:0] mask, input int delay, input logic [RW-1:0] res,
                         input logic [OPW-1:0] a_ops, input logic [OPW-1:0] b_ops, input bit spur_issue);
    int g, t0, k, exp_off;
    bit ok_done, noisy;
    logic [DW-1:0] ea, eb;
    logic [NR-1:0] oh;
    i_req_multiplier   = a_ops;
    i_req_multiplicand = b_ops;
    i_req_valid        = mask;
    core_delay         = delay;
    core_result        = res;
    g       = rr_pick(model_last, mask);
    oh      = NR'(1) << g;
    ea      = a_ops[g*DW +: DW];
    eb      = b_ops[g*DW +: DW];
    ok_done = (delay >= 1 && delay <= TO);
    exp_off = ok_done ? 2 + delay : 2 + TO;
    #1;
    k = 0;
    while (o_req_ready == '0 && k < 30) begin
      @(negedge i_clk); #1; k++;
    end
    t0 = cyc;
    last_accept   = t0;
    last_ready_oh = o_req_ready;
    check("grant", o_req_ready, oh);
    @(negedge i_clk); #1;
    check("start", o_mul_start, 1);
    check("ready_in_issue", o_req_ready, 0);
    check("mul_a", o_mul_multiplier, ea);
    check("mul_b", o_mul_multiplicand, eb);
    if (spur_issue) spur_done = 1'b1;
    noisy = 1'b0;
    k = 0;
    do begin
      @(negedge i_clk); #1;
      spur_done = 1'b0;
      noisy |= (o_req_ready != '0) || !o_busy || o_mul_start ||
               (o_mul_multiplier != ea) || (o_mul_multiplicand != eb);
      k++;
    end while (o_rsp_valid == '0 && k < 40);
    check("rsp_latency", cyc - t0, exp_off);
    check("rsp_valid", o_rsp_valid, oh);
    check("rsp_data", o_rsp_data, ok_done ? res : '0);
    check("rsp_err", o_rsp_err, !ok_done);
    check("quiet_while_busy", noisy, 0);
    model_last = g;
    last_rsp   = cyc;
    @(negedge i_clk); #1;
    check("rsp_one_cycle", o_rsp_valid, 0);
  endtask

  initial begin
    logic [NR-1:0] rr_exp [5];
    int dtab [6];
    int prev_rsp, k;
    bit stray;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    dtab   = '{1, 2, 3, 5, 15, 0};
    i_rst = 1'b0;
    i_req_valid = '1;
    i_req_multiplier = OPW'($urandom);
    i_req_multiplicand = OPW'($urandom);
    repeat (3) @(negedge i_clk);
    #1;
    check("rst_outputs", {o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_mul_start,
                          o_mul_multiplier, o_mul_multiplicand, o_busy}, 0);

    // Continuous requests from everyone: strict rotation, back-to-back grants.
    i_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prev_rsp = last_rsp;
      run_txn(4'hF, 1, RW'($urandom), OPW'($urandom), OPW'($urandom), 1'b0);
      check("rr_order", last_ready_oh, rr_exp[i]);
      if (i > 0) check("back_to_back", last_accept - prev_rsp, 1);
    end
    i_req_valid = '0;
    @(negedge i_clk);

    // Single request with known operands and result.
    run_txn(4'b0001, 1, 9'h03F, 16'h0007, 16'h0009, 1'b0);
    // Timeout, then a normal operation afterwards.
    run_txn(4'b0010, 0, RW'($urandom), OPW'($urandom), OPW'($urandom), 1'b0);
    run_txn(4'b0010, 2, RW'($urandom), OPW'($urandom), OPW'($urandom), 1'b0);
    // Done on the very cycle the wait limit is reached.
    run_txn(4'b0100, TO, RW'($urandom), OPW'($urandom), OPW'($urandom), 1'b0);

    // Spurious done in IDLE.
    i_req_valid = '0;
    @(negedge i_clk); #1;
    spur_done = 1'b1;
    @(negedge i_clk); #1;
    spur_done = 1'b0;
    check("spur_idle_busy", o_busy, 0);
    check("spur_idle_rsp", o_rsp_valid, 0);
    @(negedge i_clk); #1;
    check("spur_idle_rsp2", o_rsp_valid, 0);
    // Spurious done in ISSUE with a silent core must still time out.
    run_txn(4'b1000, 0, RW'($urandom), OPW'($urandom), OPW'($urandom), 1'b1);

    for (int i = 0; i < 8; i++) begin
      run_txn(NR'($urandom_range(1, 15)), dtab[$urandom_range(0, 5)], RW'($urandom),
              OPW'($urandom), OPW'($urandom), 1'b0);
    end

    // Reset during WAIT: abort silently, restart with fresh priority.
    i_req_valid = 4'b0100;
    core_delay = 0;
    #1;
    k = 0;
    while (o_req_ready == '0 && k < 30) begin
      @(negedge i_clk); #1; k++;
    end
    repeat (3) @(negedge i_clk);
    #1;
    check("pre_reset_busy", o_busy, 1);
    i_rst = 1'b0;
    i_req_valid = 4'b0101;
    #1;
    check("midop_rst_outputs", {o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_mul_start,
                                o_mul_multiplier, o_mul_multiplicand, o_busy}, 0);
    stray = 1'b0;
    repeat (3) begin
      @(negedge i_clk); #1;
      stray |= (o_rsp_valid != '0) || (o_req_ready != '0);
    end
    check("midop_rst_silent", stray, 0);
    model_last = NR - 1;
    i_rst = 1'b1;
    run_txn(4'b0101, 1, RW'($urandom), OPW'($urandom), OPW'($urandom), 1'b0);
    check("post_rst_first", last_ready_oh, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
